// File: rtl/stream_fifo_tx_if.sv
// stream_fifo_tx_if: AXI-Stream-style beat channel (tdata/tvalid/tlast with
// tready back-pressure) between the stream FIFO source and its consumer.
interface stream_fifo_tx_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/stream_fifo_tx.sv
// stream_fifo_tx: circular FIFO of {last, data} words drained onto a
// stream master through a single output register.
// The writer pushes at any time; words are dropped when storage is full.
// Optional build macro STREAM_FIFO_STATS_EN adds the sticky overflow flag and
// a saturating drop counter; without it drops are silent.
module stream_fifo_tx #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  din,
  input  logic           din_last,
  input  logic           push,
  input  logic           op_en,
  stream_fifo_tx_if.master tx,
  output logic [AW:0]    count,
  output logic           empty,
  output logic           full
`ifdef STREAM_FIFO_STATS_EN
  ,
  output logic           overflow,
  output logic [15:0]    drop_count
`endif
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          load;

  // Status is decoded from the count register only, so it never depends on
  // the same-cycle push or pop.
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A push while full is dropped even when a beat leaves in the same cycle.
  assign wr_en = push && !full;
  // New beat is taken when the output register is free or being emptied.
  assign load  = op_en && !empty && (!tx.tvalid || tx.tready);

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= {din_last, din};
    end
  end

  // Read and write pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (load)  rptr <= rptr + PTR_ONE;
    end
  end

  // Output register: load a new beat, or retire the accepted one while
  // keeping the data/last values; hold everything under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx.tdata  <= '0;
      tx.tlast  <= 1'b0;
      tx.tvalid <= 1'b0;
    end else if (load) begin
      tx.tdata  <= mem[rptr][DW-1:0];
      tx.tlast  <= mem[rptr][DW];
      tx.tvalid <= 1'b1;
    end else if (tx.tready) begin
      tx.tvalid <= 1'b0;
    end
  end

  // Occupancy of storage only; the output register is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({wr_en, load})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef STREAM_FIFO_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Drop statistics: sticky flag plus saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push && full) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc16(drop_count);
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo_tx.sv
// tb_stream_fifo_tx: scoreboard bench for stream_fifo_tx with a queue-based
// reference model; directed scenarios followed by a randomized phase.
module tb_stream_fifo_tx;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_last = 1'b0;
  logic          push = 1'b0;
  logic          op_en = 1'b0;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
`ifdef STREAM_FIFO_STATS_EN
  logic          overflow;
  logic [15:0]   drop_count;
`endif

  stream_fifo_tx_if #(.DW(DW)) tx_if ();

  stream_fifo_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_last (din_last),
    .push     (push),
    .op_en    (op_en),
    .tx       (tx_if.master),
    .count    (count),
    .empty    (empty),
    .full     (full)
`ifdef STREAM_FIFO_STATS_EN
    ,
    .overflow   (overflow),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int beats  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: words in storage, expected beat order, output occupancy.
  logic [DW:0] mq[$];
  logic [DW:0] sb[$];
  bit          m_vld = 1'b0;
  int          m_drops = 0;
  bit          m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      sb.delete();
      m_vld   = 1'b0;
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      bit acc;
      bit ld;
      acc = push && (mq.size() < DEPTH);
      ld  = op_en && (mq.size() > 0) && (!m_vld || tx_if.tready);
      if (push && !acc) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      if (ld) begin
        void'(mq.pop_front());
        m_vld = 1'b1;
      end else if (tx_if.tready) begin
        m_vld = 1'b0;
      end
      if (acc) begin
        mq.push_back({din_last, din});
        sb.push_back({din_last, din});
      end
    end
  end

  // Monitor: compare each accepted beat with the scoreboard and check that
  // a stalled beat stays stable.
  bit            hold_prev = 1'b0;
  logic [DW-1:0] data_prev;
  logic          last_prev;

  always @(posedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        check("hold_tvalid", tx_if.tvalid, 1);
        check("hold_tdata", tx_if.tdata, data_prev);
        check("hold_tlast", tx_if.tlast, last_prev);
      end
      if (tx_if.tvalid && tx_if.tready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL beat_unexpected: got %0h, required no beat", tx_if.tdata);
        end else begin
          logic [DW:0] e;
          e = sb.pop_front();
          check("beat_tdata", tx_if.tdata, e[DW-1:0]);
          check("beat_tlast", tx_if.tlast, e[DW]);
        end
        beats++;
      end
      hold_prev = tx_if.tvalid && !tx_if.tready;
      data_prev = tx_if.tdata;
      last_prev = tx_if.tlast;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Status comparison once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("tvalid", tx_if.tvalid, m_vld);
`ifdef STREAM_FIFO_STATS_EN
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
`endif
    end
  end

  task automatic drive(input bit p, input logic [DW-1:0] d, input bit l);
    push     = p;
    din      = d;
    din_last = l;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    drive(0, '0, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_tvalid", tx_if.tvalid, 0);
    check("rst_tdata", tx_if.tdata, 0);
    check("rst_tlast", tx_if.tlast, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
`ifdef STREAM_FIFO_STATS_EN
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int cycles);
    @(negedge clk);
    drive(0, '0, 0);
    op_en        = 1'b1;
    tx_if.tready = 1'b1;
    repeat (cycles) @(negedge clk);
    check("drain_sb_empty", sb.size(), 0);
    check("drain_empty", empty, 1);
  endtask

  initial begin
    int b0;
    bit seen;
    tx_if.tready = 1'b0;
    repeat (2) @(negedge clk);

    // Fill with output disabled, then drain at full rate.
    do_reset();
    op_en = 1'b0;
    tx_if.tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      drive(1, DW'(i), i == 16);
    end
    @(negedge clk);
    drive(0, '0, 0);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    op_en = 1'b1;
    b0 = beats;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("drain_consecutive", tx_if.tvalid, 1);
    end
    @(negedge clk);
    check("drain_beats", beats - b0, 16);
    check("drain_final_empty", empty, 1);
    check("drain_final_tvalid", tx_if.tvalid, 0);

    // Back-pressure on a pending 0xA5 beat while op_en toggles.
    do_reset();
    op_en = 1'b1;
    tx_if.tready = 1'b0;
    @(negedge clk); drive(1, 8'hA5, 0);
    @(negedge clk); drive(1, 8'h3C, 1);
    @(negedge clk); drive(0, '0, 0);
    check("bp_tdata", tx_if.tdata, 8'hA5);
    check("bp_tvalid", tx_if.tvalid, 1);
    for (int i = 0; i < 5; i++) begin
      op_en = i[0];
      @(negedge clk);
      check("bp_hold_tdata", tx_if.tdata, 8'hA5);
      check("bp_hold_tvalid", tx_if.tvalid, 1);
      check("bp_hold_count", count, 1);
    end
    drain(6);

    // Overflow: three drops while full, then one more during the first pop.
    do_reset();
    op_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1, DW'($urandom_range(0, 8'hED)), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 8'hEE, 1);
    end
    @(negedge clk);
    drive(0, '0, 0);
    check("ovf_count", count, 16);
`ifdef STREAM_FIFO_STATS_EN
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 3);
`endif
    op_en = 1'b1;
    tx_if.tready = 1'b1;
    drive(1, 8'hEE, 0);
    @(negedge clk);
    drive(0, '0, 0);
    check("ovf_nobypass_count", count, 15);
    drain(24);

    // Steady push+pop across pointer wrap keeps occupancy constant.
    do_reset();
    op_en = 1'b0;
    tx_if.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, DW'(8'hC0 + i), 0);
    end
    @(negedge clk);
    op_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(1, DW'(i * 7 + 3), (i % 9) == 8);
      @(negedge clk);
      check("wrap_count", count, 5);
    end
    drain(10);

    // Reset with a pending beat and 7 stored words, then restart cleanly.
    do_reset();
    op_en = 1'b1;
    tx_if.tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, DW'(8'h10 + i), 0);
    end
    @(negedge clk);
    drive(0, '0, 0);
    check("pre_rst_count", count, 7);
    check("pre_rst_tvalid", tx_if.tvalid, 1);
    do_reset();
    tx_if.tready = 1'b1;
    op_en = 1'b1;
    drive(1, 8'h5A, 1);
    @(negedge clk);
    drive(0, '0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_if.tvalid) begin
        seen = 1'b1;
        check("post_rst_first_beat", tx_if.tdata, 8'h5A);
      end
    end
    check("post_rst_beat_seen", seen, 1);
    drain(4);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 3) == 0);
      op_en        = $urandom_range(0, 99) < 85;
      tx_if.tready = $urandom_range(0, 99) < 70;
    end
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stream_fifo_tx.md
# stream_fifo_tx

Parametrised byte/word stream source for the I2C testbench. Buffers words pushed by the stimulus side in a circular FIFO and drains them onto an AXI-Stream-style master interface (tdata/tvalid/tready/tlast) with full handshake compliance. Writes and reads run concurrently, and tlast is carried per word from the writer. Sits between the testbench sequencer and the I2C master model's transmit input.

## Interface

Parameters:
- DW, 8, data width in bits
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports (clock and reset first). One clock; reset is asynchronous and active-high.
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  DW  write data
- din_last  input  1  packet-end marker stored with din
- push  input  1  write strobe
- op_en  input  1  output enable; gates loading of new beats
- tready  input  1  downstream ready
- tdata  output  DW  stream data
- tvalid  output  1  stream valid
- tlast  output  1  last beat of packet
- count  output  AW+1  words held in FIFO storage, excluding the output register
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky drop flag; only with STREAM_FIFO_STATS_EN
- drop_count  output  16  dropped pushes, saturating; only with STREAM_FIFO_STATS_EN

## Operation

- Storage holds DEPTH entries of {din_last, din}. wptr and rptr are AW bits wide and wrap modulo DEPTH. count is an AW+1-bit register.
- Write: when push && !full, store {din_last, din} at wptr and increment wptr. When push && full, drop the word; storage, pointers and count stay unchanged. No bypass: a push while full is dropped even if a pop occurs in the same cycle.
- Output register holds tdata, tlast and tvalid.
- Load condition: op_en && !empty && (!tvalid || tready). On load, tdata/tlast take entry[rptr], tvalid is set to 1 and rptr increments.
- When tvalid && tready and no load occurs in the same cycle, tvalid goes to 0. tdata and tlast hold their last values.
- While tvalid=1 && tready=0, tdata, tlast and tvalid hold stable. Deasserting op_en never retracts a pending beat; it only blocks new loads.
- count update: +1 on accepted write only, −1 on load only, unchanged when both occur.
- empty and full are decoded combinationally from the count register.
- Pushes are accepted regardless of op_en.
- Reset mid-operation discards all content, including a beat pending on the output.

## Timing

- Reset values: tdata=0, tvalid=0, tlast=0, count=0, empty=1, full=0, overflow=0, drop_count=0. Storage contents are not reset.
- Write latency: push sampled at edge N updates count/empty/full after edge N.
- Earliest output: a word pushed at edge N into an empty FIFO, with op_en=1 and the output register free, appears with tvalid=1 after edge N+1.
- Throughput: one beat per cycle while tready=1, op_en=1 and !empty.
- tlast is asserted exactly on beats whose stored din_last=1. It is not inferred from the FIFO draining.

## Configuration

- STREAM_FIFO_STATS_EN defined:
  - Adds the overflow and drop_count ports.
  - Each dropped push sets overflow, which stays at 1 until rst.
  - Each dropped push increments drop_count, saturating at 16'hFFFF.
- STREAM_FIFO_STATS_EN undefined:
  - The two ports and their logic are absent.
  - Drops are silent.
  - All other behaviour is identical.

## Test plan

- Fill and drain: DW=8, DEPTH=16, op_en=0; push 0x01..0x10 with din_last=1 on 0x10 → full=1, count=16. Then op_en=1, tready=1 → beats 0x01..0x10 on 16 consecutive cycles; tlast=1 only on 0x10; empty=1 afterwards.
- Backpressure: tvalid=1 with tdata=0xA5, hold tready=0 for 5 cycles while toggling op_en → tdata=0xA5 and tvalid=1 stay constant; count unchanged.
- Overflow: while full, push 0xEE three times → count stays 16 and 0xEE never appears on tdata. With STREAM_FIFO_STATS_EN: overflow=1, drop_count=3.
- Wrap-around and concurrency: stream 40 words with simultaneous push and pop each cycle, tready=1 → count stays constant; output order matches input order across pointer wrap.
- Reset mid-stream: assert rst asynchronously with count=7 and tvalid=1 → outputs take reset values immediately, without waiting for a clock edge. A subsequent push of 0x5A emits 0x5A as the first beat.
